// File: rtl/julia_pkg.sv
// Shared types and constants for the Julia frame-buffer write path.
package julia_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_req_t;

  typedef enum logic {
    IDLE,
    ACK
  } ctl_state_t;

  localparam int FRAME_W         = 640;
  localparam int FRAME_H         = 480;
  localparam int BYTES_PER_PIXEL = 4;

endpackage

// File: rtl/wr_req_fifo.sv
// First-word-fall-through request buffer; dout is the head entry whenever
// empty is low.
module wr_req_fifo
  import julia_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          push,
  input  logic          pop,
  input  wr_req_t       din,
  output wr_req_t       dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  wr_req_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/julia_wr_master.sv
// Buffers pixel writes from julia_wrapper and drains them to the frame
// buffer over an Avalon-MM write master, flagging each completed frame.
module julia_wr_master
  import julia_pkg::*;
#(
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          FRAME_PIXELS = 307200
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start_sig,
  input  logic        wr_ready,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  output logic        wr_done,
  output logic [31:0] avm_address,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        frame_done
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = $clog2(FRAME_PIXELS + 1);

  ctl_state_t    state;
  wr_req_t       req;
  wr_req_t       head;
  logic          full;
  logic          empty;
  logic [CW-1:0] occ;
  logic          push;
  logic          pop;
  logic [PW-1:0] pix_cnt;

  assign push = wr_ready && !full && (state == IDLE);
  assign pop  = !empty && !avm_waitrequest;

  assign req.addr = wr_addr + BASE_ADDR;
  assign req.data = wr_data;

  wr_req_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .n_rst(n_rst),
    .push (push),
    .pop  (pop),
    .din  (req),
    .dout (head),
    .full (full),
    .empty(empty),
    .count(occ)
  );

  // Stale FIFO slots are masked so the bus idles at zero.
  assign avm_write      = !empty;
  assign avm_address    = empty ? '0 : head.addr;
  assign avm_writedata  = empty ? '0 : head.data;
  assign avm_byteenable = 4'b1111;
  assign busy           = (occ != '0);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      wr_done <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (push) begin
            state   <= ACK;
            wr_done <= 1'b1;
          end
        end
        ACK: begin
          state   <= IDLE;
          wr_done <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pix_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (start_sig) begin
        pix_cnt <= '0;
      end else if (pop) begin
        if (pix_cnt + 1'b1 == PW'(FRAME_PIXELS)) begin
          pix_cnt    <= '0;
          frame_done <= 1'b1;
        end else begin
          pix_cnt <= pix_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_julia_wr_master.sv
// Scoreboard bench for julia_wr_master: driver queues expected Avalon
// writes, a negedge monitor checks bus, acks and frame pulses.
module tb_julia_wr_master;
  import julia_pkg::*;

  logic        tb_clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        start_sig = 1'b0;
  logic        wr_ready = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        avm_waitrequest = 1'b0;
  logic        wr_done;
  logic [31:0] avm_address;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        busy;
  logic        frame_done;

  julia_wr_master #(
    .FIFO_DEPTH  (4),
    .BASE_ADDR   (32'h0000_1000),
    .FRAME_PIXELS(4)
  ) dut (
    .clk            (tb_clk),
    .n_rst          (n_rst),
    .start_sig      (start_sig),
    .wr_ready       (wr_ready),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_done        (wr_done),
    .avm_address    (avm_address),
    .avm_write      (avm_write),
    .avm_writedata  (avm_writedata),
    .avm_byteenable (avm_byteenable),
    .avm_waitrequest(avm_waitrequest),
    .busy           (busy),
    .frame_done     (frame_done)
  );

  always #5 tb_clk = ~tb_clk;

  int      checks = 0;
  int      failures = 0;
  wr_req_t exp_q[$];
  int      done_cnt = 0;
  int      fd_cnt = 0;
  int      mdl_cnt = 0;
  logic    exp_fd = 1'b0;
  logic    prev_done = 1'b0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge tb_clk) begin
    if (!n_rst) begin
      mdl_cnt   = 0;
      exp_fd    = 1'b0;
      prev_done = 1'b0;
    end else begin
      chk("frame_done", 32'(frame_done), 32'(exp_fd));
      if (frame_done) fd_cnt++;
      if (wr_done) begin
        done_cnt++;
        chk("wr_done_width", 32'(prev_done), 32'd0);
      end
      prev_done = wr_done;
      chk("byteenable", 32'(avm_byteenable), 32'hF);
      if (avm_write) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual=%h required=none",
                   avm_address);
        end else begin
          chk("avm_address", avm_address, exp_q[0].addr);
          chk("avm_writedata", avm_writedata, exp_q[0].data);
          if (!avm_waitrequest) void'(exp_q.pop_front());
        end
      end
      exp_fd = 1'b0;
      if (start_sig) begin
        mdl_cnt = 0;
      end else if (avm_write && !avm_waitrequest) begin
        mdl_cnt++;
        if (mdl_cnt == 4) begin
          mdl_cnt = 0;
          exp_fd  = 1'b1;
        end
      end
    end
  end

  task automatic send(input logic [31:0] a,
                      input logic [31:0] d,
                      input logic [31:0] ea);
    wr_req_t e;
    bit      got;
    e.addr = ea;
    e.data = d;
    exp_q.push_back(e);
    @(posedge tb_clk);
    #1;
    wr_addr  = a;
    wr_data  = d;
    wr_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge tb_clk);
      if (wr_done) got = 1'b1;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=no_ack required=ack data=%h", d);
    end else begin
      chk("write_after_ack", 32'(avm_write), 32'd1);
    end
    @(posedge tb_clk);
    #1;
    wr_ready = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    do begin
      @(negedge tb_clk);
      n++;
    end while ((exp_q.size() != 0 || busy) && n < 100);
    chk("drain_queue", 32'(exp_q.size()), 32'd0);
    chk("drain_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int d0;
    #12;
    chk("rst_wr_done", 32'(wr_done), 32'd0);
    chk("rst_avm_write", 32'(avm_write), 32'd0);
    chk("rst_avm_address", avm_address, 32'd0);
    chk("rst_avm_writedata", avm_writedata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_byteenable", 32'(avm_byteenable), 32'hF);
    @(posedge tb_clk);
    #1;
    n_rst = 1'b1;

    send(32'h20, 32'hDEADBEEF, 32'h1020);
    @(negedge tb_clk);
    chk("busy_fall", 32'(busy), 32'd0);
    send(32'hFFFF_F010, 32'hCAFE_0001, 32'h0000_0010);
    wait_drain();

    @(posedge tb_clk);
    #1;
    avm_waitrequest = 1'b1;
    d0 = done_cnt;
    fork
      begin
        for (int i = 1; i <= 6; i++)
          send(32'(i * 4), 32'(i), 32'h1000 + 32'(i * 4));
      end
      begin
        repeat (30) @(negedge tb_clk);
        chk("full_acks", 32'(done_cnt - d0), 32'd4);
        chk("full_busy", 32'(busy), 32'd1);
        @(posedge tb_clk);
        #1;
        avm_waitrequest = 1'b0;
      end
    join
    wait_drain();

    @(posedge tb_clk);
    #1;
    start_sig = 1'b1;
    @(posedge tb_clk);
    #1;
    start_sig = 1'b0;
    for (int i = 0; i < 3; i++)
      send(32'h100 + 32'(i * 4), 32'hA0 + 32'(i), 32'h1100 + 32'(i * 4));
    wait_drain();
    avm_waitrequest = 1'b1;
    send(32'h10C, 32'hA3, 32'h110C);
    start_sig       = 1'b1;
    avm_waitrequest = 1'b0;
    @(posedge tb_clk);
    #1;
    start_sig = 1'b0;
    wait_drain();
    for (int i = 0; i < 4; i++)
      send(32'h200 + 32'(i * 4), 32'hB0 + 32'(i), 32'h1200 + 32'(i * 4));
    wait_drain();
    repeat (3) @(negedge tb_clk);
    chk("frame_pulses", 32'(fd_cnt), 32'd3);

    avm_waitrequest = 1'b1;
    for (int i = 0; i < 3; i++)
      send(32'h300 + 32'(i * 4), 32'hC0 + 32'(i), 32'h1300 + 32'(i * 4));
    @(posedge tb_clk);
    #3;
    n_rst = 1'b0;
    #1;
    chk("arst_avm_write", 32'(avm_write), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_wr_done", 32'(wr_done), 32'd0);
    exp_q.delete();
    @(posedge tb_clk);
    #1;
    n_rst = 1'b1;
    avm_waitrequest = 1'b0;
    repeat (10) @(negedge tb_clk);
    chk("post_rst_idle", 32'(avm_write), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
